// File: rtl/control_pkg.sv
// control_pkg
// Shared encodings for the RV32I main decoder / ALU-control unit:
// opcode and funct constants, ALU operation codes, instruction-format
// classes, the reset/invalid output values and a small funct3 helper.
package control_pkg;

  // Major opcodes (instr[6:0]) recognised by the decoder.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct7 values that select the base and alternate operations.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 values that need special handling.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    TYPE_R       = 3'b000,
    TYPE_I       = 3'b001,
    TYPE_S       = 3'b010,
    TYPE_B       = 3'b011,
    TYPE_U       = 3'b100,
    TYPE_J       = 3'b101,
    TYPE_INVALID = 3'b111
  } inst_type_e;

  // Values driven while in reset.
  localparam alu_ctrl_e  RESET_ALU_CTRL  = ALU_ADD;
  localparam logic       RESET_SHAMT_EN  = 1'b0;
  localparam logic       RESET_REG_WRITE = 1'b0;
  localparam inst_type_e RESET_INST_TYPE = TYPE_INVALID;

  // Values driven for undecodable words; reg_write must stay low so the
  // register file is never written by garbage.
  localparam alu_ctrl_e  INVALID_ALU_CTRL  = ALU_ADD;
  localparam logic       INVALID_SHAMT_EN  = 1'b0;
  localparam logic       INVALID_REG_WRITE = 1'b0;
  localparam inst_type_e INVALID_INST_TYPE = TYPE_INVALID;

  // Base (funct7 = 0000000) ALU operation selected by funct3, shared by
  // the register-register and register-immediate arithmetic groups.
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_r_decode.sv
// control_r_decode
// Purely combinational RV32I main decoder. Produces the next-cycle values
// of the control outputs from one instruction word.
// Ports:
//   instruction_word  in  32  instruction to decode
//   alu_ctrl_d        out  4  ALU operation code
//   shamt_en_d        out  1  operand B is instr[24:20]
//   reg_write_d       out  1  register-file write enable
//   inst_type_d       out  3  instruction format class
module control_r_decode
  import control_pkg::*;
(
  input  logic [31:0] instruction_word,
  output alu_ctrl_e   alu_ctrl_d,
  output logic        shamt_en_d,
  output logic        reg_write_d,
  output inst_type_e  inst_type_d
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instruction_word[6:0];
  assign funct3 = instruction_word[14:12];
  assign funct7 = instruction_word[31:25];

  // Register specifiers and immediates are consumed by other blocks; rd in
  // particular does not gate reg_write (x0 is handled by the register file).
  assign unused_fields = ^{instruction_word[24:15], instruction_word[11:7]};

  // Every path starts from the invalid defaults and only overrides them
  // once the word is known to be legal.
  always_comb begin
    alu_ctrl_d  = INVALID_ALU_CTRL;
    shamt_en_d  = INVALID_SHAMT_EN;
    reg_write_d = INVALID_REG_WRITE;
    inst_type_d = INVALID_INST_TYPE;

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          alu_ctrl_d  = alu_from_funct3(funct3);
          reg_write_d = 1'b1;
          inst_type_d = TYPE_R;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          alu_ctrl_d  = ALU_SUB;
          reg_write_d = 1'b1;
          inst_type_d = TYPE_R;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          alu_ctrl_d  = ALU_SRA;
          reg_write_d = 1'b1;
          inst_type_d = TYPE_R;
        end
      end

      // Shift-immediates reuse funct7 as an encoding qualifier, so only
      // those two funct3 values look at it; all others ignore the upper
      // immediate bits (and 000 is always ADDI, there is no SUBI).
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL) begin
          if (funct7 == F7_BASE) begin
            alu_ctrl_d  = ALU_SLL;
            shamt_en_d  = 1'b1;
            reg_write_d = 1'b1;
            inst_type_d = TYPE_I;
          end
        end else if (funct3 == F3_SR) begin
          if (funct7 == F7_BASE || funct7 == F7_ALT) begin
            alu_ctrl_d  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            shamt_en_d  = 1'b1;
            reg_write_d = 1'b1;
            inst_type_d = TYPE_I;
          end
        end else begin
          alu_ctrl_d  = alu_from_funct3(funct3);
          reg_write_d = 1'b1;
          inst_type_d = TYPE_I;
        end
      end

      // Load width legality is checked by the memory stage.
      OPC_LOAD, OPC_JALR: begin
        alu_ctrl_d  = ALU_ADD;
        reg_write_d = 1'b1;
        inst_type_d = TYPE_I;
      end

      OPC_STORE: begin
        alu_ctrl_d  = ALU_ADD;
        inst_type_d = TYPE_S;
      end

      // Branch comparison is done by subtraction in the ALU.
      OPC_BRANCH: begin
        alu_ctrl_d  = ALU_SUB;
        inst_type_d = TYPE_B;
      end

      OPC_LUI: begin
        alu_ctrl_d  = ALU_PASS_B;
        reg_write_d = 1'b1;
        inst_type_d = TYPE_U;
      end

      OPC_AUIPC: begin
        alu_ctrl_d  = ALU_ADD;
        reg_write_d = 1'b1;
        inst_type_d = TYPE_U;
      end

      OPC_JAL: begin
        alu_ctrl_d  = ALU_ADD;
        reg_write_d = 1'b1;
        inst_type_d = TYPE_J;
      end

      default: begin
        alu_ctrl_d  = INVALID_ALU_CTRL;
        shamt_en_d  = INVALID_SHAMT_EN;
        reg_write_d = INVALID_REG_WRITE;
        inst_type_d = INVALID_INST_TYPE;
      end
    endcase
  end

endmodule

// File: rtl/control_r.sv
// control_r
// Registered RV32I main decoder / ALU-control unit. Outputs follow the
// instruction word sampled at the previous rising edge.
// Ports:
//   clk               in   1  system clock
//   rst               in   1  synchronous active-high reset
//   instruction_word  in  32  instruction to decode
//   alu_ctrl          out  4  ALU operation code
//   shamt_en          out  1  operand B is instr[24:20]
//   reg_write         out  1  register-file write enable for rd
//   inst_type         out  3  instruction format class
module control_r
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_word,
  output logic [3:0]  alu_ctrl,
  output logic        shamt_en,
  output logic        reg_write,
  output logic [2:0]  inst_type
);

  alu_ctrl_e  alu_ctrl_d,  alu_ctrl_q;
  logic       shamt_en_d,  shamt_en_q;
  logic       reg_write_d, reg_write_q;
  inst_type_e inst_type_d, inst_type_q;

  control_r_decode u_decode (
    .instruction_word (instruction_word),
    .alu_ctrl_d       (alu_ctrl_d),
    .shamt_en_d       (shamt_en_d),
    .reg_write_d      (reg_write_d),
    .inst_type_d      (inst_type_d)
  );

  // Output register; reset takes priority over whatever is being decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl_q  <= RESET_ALU_CTRL;
      shamt_en_q  <= RESET_SHAMT_EN;
      reg_write_q <= RESET_REG_WRITE;
      inst_type_q <= RESET_INST_TYPE;
    end else begin
      alu_ctrl_q  <= alu_ctrl_d;
      shamt_en_q  <= shamt_en_d;
      reg_write_q <= reg_write_d;
      inst_type_q <= inst_type_d;
    end
  end

  assign alu_ctrl  = alu_ctrl_q;
  assign shamt_en  = shamt_en_q;
  assign reg_write = reg_write_q;
  assign inst_type = inst_type_q;

endmodule

// File: tb/tb_control_r.sv
// tb_control_r
// Self-checking bench for control_r. Directed scenarios use constant
// expectations; random back-to-back traffic is compared against a
// table-driven reference decoder. Observed/expected values are packed as
// {alu_ctrl[3:0], shamt_en, reg_write, inst_type[2:0]}.
module tb_control_r;

  logic        clk;
  logic        rst;
  logic [31:0] instruction_word;
  logic [3:0]  alu_ctrl;
  logic        shamt_en;
  logic        reg_write;
  logic [2:0]  inst_type;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] EXP_RESET   = 9'b0000_0_0_111;
  localparam logic [8:0] EXP_INVALID = 9'b0000_0_0_111;

  // ALU code for each funct3 in the base arithmetic group.
  localparam logic [3:0] ALU_BY_F3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  // Opcodes the random generator draws from.
  localparam logic [6:0] OPCODES [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                         7'h63, 7'h37, 7'h17, 7'h6F};

  control_r dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_word (instruction_word),
    .alu_ctrl         (alu_ctrl),
    .shamt_en         (shamt_en),
    .reg_write        (reg_write),
    .inst_type        (inst_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] observed();
    return {alu_ctrl, shamt_en, reg_write, inst_type};
  endfunction

  // Reference decoder written from the instruction-set rules.
  function automatic logic [8:0] ref_decode(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    case (op)
      7'h33: begin
        if (f7 == 7'h00) return {ALU_BY_F3[f3], 1'b0, 1'b1, 3'd0};
        if (f7 == 7'h20 && f3 == 3'd0) return {4'd1, 1'b0, 1'b1, 3'd0};
        if (f7 == 7'h20 && f3 == 3'd5) return {4'd7, 1'b0, 1'b1, 3'd0};
        return EXP_INVALID;
      end
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? {4'd2, 1'b1, 1'b1, 3'd1} : EXP_INVALID;
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) return {4'd6, 1'b1, 1'b1, 3'd1};
          if (f7 == 7'h20) return {4'd7, 1'b1, 1'b1, 3'd1};
          return EXP_INVALID;
        end
        return {ALU_BY_F3[f3], 1'b0, 1'b1, 3'd1};
      end
      7'h03, 7'h67: return {4'd0, 1'b0, 1'b1, 3'd1};
      7'h23:        return {4'd0, 1'b0, 1'b0, 3'd2};
      7'h63:        return {4'd1, 1'b0, 1'b0, 3'd3};
      7'h37:        return {4'd10, 1'b0, 1'b1, 3'd4};
      7'h17:        return {4'd0, 1'b0, 1'b1, 3'd4};
      7'h6F:        return {4'd0, 1'b0, 1'b1, 3'd5};
      default:      return EXP_INVALID;
    endcase
  endfunction

  // Drive inputs at the falling edge, then wait until just after the next
  // rising edge so the registered outputs reflect this word.
  task automatic step(input logic r, input logic [31:0] w);
    @(negedge clk);
    rst = r;
    instruction_word = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] add_w;
    add_w = 32'b0000000_00100_10101_000_00101_0110011;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, add_w);
      checks++;
      if (observed() !== EXP_RESET) begin
        errors++;
        $display("[TB] FAIL reset_hold%0d: got %b expected %b", i, observed(), EXP_RESET);
      end
    end
    step(1'b0, add_w);
    checks++;
    if (observed() !== 9'b0000_0_1_000) begin
      errors++;
      $display("[TB] FAIL reset_release_add: got %b expected %b", observed(), 9'b0000_0_1_000);
    end
  endtask

  task automatic test_rtype();
    step(1'b0, 32'b0100000_00101_10101_000_00110_0110011);
    checks++;
    if (observed() !== 9'b0001_0_1_000) begin
      errors++;
      $display("[TB] FAIL rtype_sub: got %b expected %b", observed(), 9'b0001_0_1_000);
    end
    step(1'b0, 32'b0000000_00100_10101_001_00101_0110011);
    checks++;
    if (observed() !== 9'b0010_0_1_000) begin
      errors++;
      $display("[TB] FAIL rtype_sll: got %b expected %b", observed(), 9'b0010_0_1_000);
    end
  endtask

  task automatic test_load();
    step(1'b0, 32'b001000001001_10011_000_00111_0000011);
    checks++;
    if (observed() !== 9'b0000_0_1_001) begin
      errors++;
      $display("[TB] FAIL load_lb: got %b expected %b", observed(), 9'b0000_0_1_001);
    end
    step(1'b0, 32'b011101101101_00001_111_00110_0000011);
    checks++;
    if (observed() !== 9'b0000_0_1_001) begin
      errors++;
      $display("[TB] FAIL load_f3_111: got %b expected %b", observed(), 9'b0000_0_1_001);
    end
  endtask

  task automatic test_lui_store();
    step(1'b0, 32'b00001111010101101011_01101_0110111);
    checks++;
    if (observed() !== 9'b1010_0_1_100) begin
      errors++;
      $display("[TB] FAIL lui: got %b expected %b", observed(), 9'b1010_0_1_100);
    end
    step(1'b0, 32'b0000111_10101_01101_010_01101_0100011);
    checks++;
    if (observed() !== 9'b0000_0_0_010) begin
      errors++;
      $display("[TB] FAIL store: got %b expected %b", observed(), 9'b0000_0_0_010);
    end
  endtask

  task automatic test_opimm_shift();
    step(1'b0, 32'b0100000_00011_00010_101_00001_0010011);
    checks++;
    if (observed() !== 9'b0111_1_1_001) begin
      errors++;
      $display("[TB] FAIL srai: got %b expected %b", observed(), 9'b0111_1_1_001);
    end
    step(1'b0, 32'b0100000_00011_00010_001_00001_0010011);
    checks++;
    if (observed() !== EXP_INVALID) begin
      errors++;
      $display("[TB] FAIL slli_bad_funct7: got %b expected %b", observed(), EXP_INVALID);
    end
    // ADDI with funct7 bits set is still ADDI, never SUB.
    step(1'b0, 32'b0100000_00011_00010_000_00001_0010011);
    checks++;
    if (observed() !== 9'b0000_0_1_001) begin
      errors++;
      $display("[TB] FAIL addi_high_imm: got %b expected %b", observed(), 9'b0000_0_1_001);
    end
  endtask

  task automatic test_invalid_and_midreset();
    logic [31:0] add_w;
    add_w = 32'b0000000_00100_10101_000_00101_0110011;
    step(1'b0, 32'h0000007F);
    checks++;
    if (observed() !== EXP_INVALID) begin
      errors++;
      $display("[TB] FAIL unknown_opcode: got %b expected %b", observed(), EXP_INVALID);
    end
    step(1'b1, add_w);
    checks++;
    if (observed() !== EXP_RESET) begin
      errors++;
      $display("[TB] FAIL midstream_reset: got %b expected %b", observed(), EXP_RESET);
    end
    step(1'b0, add_w);
    checks++;
    if (observed() !== 9'b0000_0_1_000) begin
      errors++;
      $display("[TB] FAIL after_midstream_reset: got %b expected %b", observed(), 9'b0000_0_1_000);
    end
  endtask

  // Random words changing every cycle; opcode and funct7 are biased toward
  // legal encodings so every decode path is exercised.
  task automatic test_back_to_back();
    logic [31:0] w;
    logic [8:0]  exp;
    for (int n = 0; n < 600; n++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = OPCODES[$urandom_range(0, 8)];
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      exp = ref_decode(w);
      step(1'b0, w);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("[TB] FAIL random word %h: got %b expected %b", w, observed(), exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    instruction_word = 32'h0;
    test_reset();
    test_rtype();
    test_load();
    test_lui_store();
    test_opimm_shift();
    test_invalid_and_midreset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
